// File: rtl/event_pulse_pkg.sv
// Shared types and defaults for the debounced event pulse generator.
package event_pulse_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_QUAL_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_QUAL_LOW  = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/event_pulse_gen_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input, cleared by reset.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/event_pulse_gen.sv
// Debounced event detector: one-cycle pulse per accepted rising edge of evt_in.
// Optional glitch counter enabled by defining EVENT_PULSE_GLITCH_CNT_EN.
module event_pulse_gen
    import event_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       evt_in,
    output logic       pulse_out,
    output logic       level_out,
    output logic       busy
`ifdef EVENT_PULSE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [7:0] Q_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic   s;
    state_e state_q, state_d;
    logic [7:0] q_q, q_d;
    logic   pulse_q, pulse_d;

    sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (evt_in),
        .q_o   (s)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = ST_QUAL_HIGH;
                    q_d     = 8'd0;
                end
            end
            ST_QUAL_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                end else if (q_q == Q_LAST) begin
                    state_d = ST_HIGH;
                end else begin
                    q_d = q_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = ST_QUAL_LOW;
                    q_d     = 8'd0;
                end
            end
            ST_QUAL_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                end else if (q_q == Q_LAST) begin
                    state_d = ST_LOW;
                end else begin
                    q_d = q_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_LOW;
                q_d     = 8'd0;
            end
        endcase
        // Only a qualified rise pulses; a glitch return from QUAL_LOW lands in HIGH silently.
        pulse_d = (state_q == ST_QUAL_HIGH) && (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            q_q     <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;
    assign level_out = (state_q == ST_HIGH) || (state_q == ST_QUAL_LOW);
    assign busy      = (state_q == ST_QUAL_HIGH) || (state_q == ST_QUAL_LOW);

`ifdef EVENT_PULSE_GLITCH_CNT_EN
    logic [7:0] glitch_q;
    logic       glitch_evt;

    assign glitch_evt = ((state_q == ST_QUAL_HIGH) && !s) ||
                        ((state_q == ST_QUAL_LOW)  &&  s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 8'd0;
        end else if (glitch_evt) begin
            glitch_q <= sat_inc8(glitch_q);
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
